// File: rtl/lmc_sequencer.sv
// lmc_sequencer: Little-Man-Computer style instruction sequencer.
// Fetches one word per instruction from a combinationally-read memory.
// The upper 4 bits of the word are the opcode and the rest are the operand.
// Executes accumulator, branch, store and handshaked I/O operations.
module lmc_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8   // must equal 4 + ADDR_WIDTH
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_HLT = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2,  OP_STA = 4'd3,
        OP_LDA = 4'd5, OP_BRA = 4'd6, OP_BRZ = 4'd7,  OP_BRP = 4'd8,
        OP_INP = 4'd9, OP_OUT = 4'd10
    } opcode_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  neg_q, neg_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    opcode_t               opcode;
    logic [ADDR_WIDTH-1:0] operand;

    assign opcode  = opcode_t'(ir_q[DATA_WIDTH-1:ADDR_WIDTH]);
    assign operand = ir_q[ADDR_WIDTH-1:0];

    // Next-state, datapath next values and combinational strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        neg_d       = neg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mem_addr    = pc_q;
        mem_we      = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_HLT: state_d = HALT;
                    OP_ADD: begin
                        mem_addr = operand;
                        acc_d    = acc_q + mem_rdata;
                        neg_d    = 1'b0;
                    end
                    OP_SUB: begin
                        // The extra top bit of the difference is the borrow.
                        mem_addr       = operand;
                        {neg_d, acc_d} = {1'b0, acc_q} - {1'b0, mem_rdata};
                    end
                    OP_STA: begin
                        mem_addr = operand;
                        mem_we   = 1'b1;
                    end
                    OP_LDA: begin
                        mem_addr = operand;
                        acc_d    = mem_rdata;
                        neg_d    = 1'b0;
                    end
                    OP_BRA: pc_d = operand;
                    OP_BRZ: if (acc_q == '0) pc_d = operand;
                    OP_BRP: if (!neg_q) pc_d = operand;
                    OP_INP: state_d = WAIT_IN;
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = WAIT_OUT;
                    end
                    default: ;  // remaining opcodes are NOPs
                endcase
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    neg_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            HALT: ;  // frozen until reset
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge timer555 or negedge reset_count) begin
        // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
        if (!reset_count) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            neg_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            neg_q       <= neg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pc        = pc_q;
    assign acc       = acc_q;
    assign mem_wdata = acc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == HALT);

endmodule

// File: doc/lmc_sequencer.md
LMC_SEQUENCER -- requirements
Module: lmc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width; DATA_WIDTH = 4 + ADDR_WIDTH is required.
REQ-003 SHALL have port timer555  in  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_count  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  in  1  start request, sampled in IDLE.
REQ-006 SHALL have port mem_addr  out  ADDR_WIDTH  program/data memory address.
REQ-007 SHALL have port mem_rdata  in  DATA_WIDTH  memory word, combinational read of mem_addr.
REQ-008 SHALL have port mem_wdata  out  DATA_WIDTH  store data, always equal to acc.
REQ-009 SHALL have port mem_we  out  1  store strobe, written at the next rising edge.
REQ-010 SHALL have port in_data  in  DATA_WIDTH  INP operand source.
REQ-011 SHALL have port in_valid  in  1  in_data valid.
REQ-012 SHALL have port in_ready  out  1  sequencer accepts in_data.
REQ-013 SHALL have port out_data  out  DATA_WIDTH  OUT result register.
REQ-014 SHALL have port out_valid  out  1  out_data valid.
REQ-015 SHALL have port out_ready  in  1  consumer takes out_data.
REQ-016 SHALL have port pc  out  ADDR_WIDTH  program counter.
REQ-017 SHALL have port acc  out  DATA_WIDTH  accumulator.
REQ-018 SHALL have port halted  out  1  high in HALT state.

Function
REQ-019 SHALL implement states IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT.
REQ-020 IDLE: stay while run=0; run=1 -> FETCH next edge.
REQ-021 FETCH: mem_addr=pc; ir <= mem_rdata; pc <= pc+1 (wraps 2**ADDR_WIDTH-1 -> 0); -> EXEC.
REQ-022 Instruction decode: opcode = ir[DATA_WIDTH-1:ADDR_WIDTH], operand = ir[ADDR_WIDTH-1:0].
REQ-023 EXEC opcodes: 0 HLT -> HALT; 1 ADD acc <= acc+mem[operand]; 2 SUB acc <= acc-mem[operand]; 3 STA mem[operand] <= acc; 5 LDA acc <= mem[operand]; 6 BRA pc <= operand; 7 BRZ pc <= operand if acc==0; 8 BRP pc <= operand if neg==0; 9 INP -> WAIT_IN; 10 OUT -> WAIT_OUT; 4, 11-15 NOP.
REQ-024 In EXEC, mem_addr SHALL equal operand for opcodes 1,2,3,5; otherwise pc.
REQ-025 mem_we SHALL be 1 only in EXEC with opcode 3; 0 in every other state.
REQ-026 ADD/SUB SHALL wrap modulo 2**DATA_WIDTH; neg <= borrow of SUB; ADD and LDA SHALL clear neg; INP SHALL clear neg.
REQ-027 BRZ/BRP SHALL use acc and neg as they stand at entry to EXEC.
REQ-028 ADD, SUB, STA, LDA, branches and NOPs SHALL return to FETCH after one EXEC cycle: 2 cycles per instruction.
REQ-029 WAIT_IN: in_ready=1; on in_valid=1 acc <= in_data, -> FETCH; else hold.
REQ-030 in_ready SHALL be 0 in every state except WAIT_IN.
REQ-031 On EXEC OUT: out_data <= acc, out_valid <= 1, -> WAIT_OUT.
REQ-032 WAIT_OUT: hold while out_ready=0; on out_ready=1 out_valid <= 0, -> FETCH; out_data stable while out_valid=1.
REQ-033 HALT: halted=1, no register changes, run ignored; exit only via reset.
REQ-034 Outside EXEC and FETCH, mem_addr SHALL equal pc.
REQ-035 A branch to the current pc, e.g. 0x60 at address 0, SHALL loop indefinitely; this is legal.

Reset
REQ-036 reset_count=0 SHALL immediately force IDLE, pc=0, acc=0, ir=0, neg=0, out_data=0, out_valid=0, halted=0, with mem_we=0 and in_ready=0.
REQ-037 Reset asserted mid-instruction, including WAIT_IN/WAIT_OUT, SHALL abandon the instruction with no memory write and no handshake completion.
REQ-038 After reset_count rises, the sequencer SHALL remain in IDLE until run=1.

Verification
REQ-039 Program {0x15,0x26,0xA0,0x00}, mem5=0x07, mem6=0x03, run pulse -> out_data=0x04, out_valid held until out_ready; then halted=1, pc=4.
REQ-040 Program {0x90,0x38,0x00}, in_valid delayed 5 cycles with in_data=0xAB -> in_ready high throughout the wait; mem8=0xAB; halted=1.
REQ-041 acc=0x02, SUB mem=0x05 then BRP 0x4 -> acc=0xFD, neg=1, branch not taken; BRZ not taken.
REQ-042 pc=0xF executing a NOP -> pc wraps to 0x0 and the next fetch is from address 0.
REQ-043 Assert reset_count=0 during WAIT_OUT with out_ready=0 -> out_valid=0, pc=0, IDLE asynchronously; no further fetch until run.
REQ-044 LDA 0xFF then ADD 0x01 -> acc=0x00, neg=0, then BRZ taken.
